// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI target holding a small register file, decoding frames of
//   [read flag | index] address field followed by write or read data, MSB first,
//   one bit per clk_serial posedge while ss_n is low.
// Ports: clk_serial/reset (sync, active-high); ss_n, mosi in, miso out (serial link);
//   reg_rd_addr -> reg_rd_data local combinational readback; wr_strobe/wr_addr/wr_data
//   one-cycle commit event; frame_active high while a frame is being decoded.
// Optional: define SPI_SLAVE_ERR_CNT_EN to add err_clear input and err_count[7:0],
//   a saturating count of frames aborted by an early ss_n rise.
module spi_slave_regfile #(
  parameter int          ADDR_BYTES = 1,
  parameter int          DATA_BYTES = 1,
  parameter int          NUM_REGS   = 16,
  parameter int unsigned RESET_VAL  = 0,
  localparam int         DW         = 8 * DATA_BYTES,
  localparam int         IW         = $clog2(NUM_REGS)
) (
  input  logic          clk_serial,
  input  logic          reset,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  input  logic [IW-1:0] reg_rd_addr,
  output logic [DW-1:0] reg_rd_data,
  output logic          wr_strobe,
  output logic [IW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
`ifdef SPI_SLAVE_ERR_CNT_EN
  input  logic          err_clear,
  output logic [7:0]    err_count,
`endif
  output logic          frame_active
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int CW = 5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_WDATA     = 3'd2;
  localparam logic [2:0] ST_RDATA     = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_flag_q, rd_flag_d;
  logic [AW-3:0] addr_sh_q, addr_sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-2:0] data_sh_q, data_sh_d;
  logic [DW-1:0] rd_sh_q, rd_sh_d;
  logic          miso_q, miso_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [IW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          frame_active_q, frame_active_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  // Address/data including the bit sampled on this edge. The index is the address
  // field below the read flag, truncated (or zero-extended) to IW bits, so indices
  // beyond NUM_REGS alias modulo NUM_REGS.
  logic [AW-2:0] addr_next;
  logic [IW-1:0] addr_idx;
  logic [DW-1:0] data_next;
  logic [DW-1:0] rd_word;

  assign addr_next = {addr_sh_q, mosi};
  assign addr_idx  = IW'(addr_next);
  assign data_next = {data_sh_q, mosi};
  assign rd_word   = regs_q[addr_idx];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_flag_d      = rd_flag_q;
    addr_sh_d      = addr_sh_q;
    idx_d          = idx_q;
    data_sh_d      = data_sh_q;
    rd_sh_d        = rd_sh_q;
    miso_d         = 1'b0;
    wr_strobe_d    = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    frame_active_d = frame_active_q;
    regs_d         = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (!ss_n) begin
          rd_flag_d      = mosi;
          cnt_d          = CW'(AW - 2);
          frame_active_d = 1'b1;
          state_d        = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ss_n) begin
          frame_active_d = 1'b0;
          state_d        = ST_IDLE;
        end else begin
          addr_sh_d = addr_next[AW-3:0];
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            idx_d = addr_idx;
            cnt_d = CW'(DW - 1);
            if (rd_flag_q) begin
              // MSB goes out on this edge so the master's first read sample sees it.
              rd_sh_d = rd_word;
              miso_d  = rd_word[DW-1];
              state_d = ST_RDATA;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
      end
      ST_WDATA: begin
        if (ss_n) begin
          frame_active_d = 1'b0;
          state_d        = ST_IDLE;
        end else begin
          data_sh_d = data_next[DW-2:0];
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            regs_d[idx_q]  = data_next;
            wr_strobe_d    = 1'b1;
            wr_addr_d      = idx_q;
            wr_data_d      = data_next;
            frame_active_d = 1'b0;
            state_d        = ST_WAIT_HIGH;
          end
        end
      end
      ST_RDATA: begin
        if (ss_n) begin
          frame_active_d = 1'b0;
          state_d        = ST_IDLE;
        end else if (cnt_q != '0) begin
          miso_d  = rd_sh_q[DW-2];
          rd_sh_d = rd_sh_q << 1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          // Master has sampled the LSB; release the line.
          frame_active_d = 1'b0;
          state_d        = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        frame_active_d = 1'b0;
        if (ss_n) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        frame_active_d = 1'b0;
        state_d        = ST_WAIT_HIGH;
      end
    endcase
  end

  // Reset lands in WAIT_HIGH so a frame cut by reset is never decoded from mid-stream.
  always_ff @(posedge clk_serial) begin
    if (reset) begin
      state_q        <= ST_WAIT_HIGH;
      cnt_q          <= '0;
      rd_flag_q      <= 1'b0;
      addr_sh_q      <= '0;
      idx_q          <= '0;
      data_sh_q      <= '0;
      rd_sh_q        <= '0;
      miso_q         <= 1'b0;
      wr_strobe_q    <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_active_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DW'(RESET_VAL);
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_flag_q      <= rd_flag_d;
      addr_sh_q      <= addr_sh_d;
      idx_q          <= idx_d;
      data_sh_q      <= data_sh_d;
      rd_sh_q        <= rd_sh_d;
      miso_q         <= miso_d;
      wr_strobe_q    <= wr_strobe_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      frame_active_q <= frame_active_d;
      regs_q         <= regs_d;
    end
  end

  // miso is forced low whenever the target is deselected.
  assign miso         = miso_q & ~ss_n;
  assign reg_rd_data  = regs_q[reg_rd_addr];
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_active = frame_active_q;

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       abort;

  always_comb begin
    abort     = ss_n && ((state_q == ST_ADDR) || (state_q == ST_WDATA) || (state_q == ST_RDATA));
    err_cnt_d = err_cnt_q;
    if (err_clear) begin
      err_cnt_d = '0;
    end else if (abort && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_serial) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: drives two spi_slave_regfile instances (8-bit and 16-bit
//   frame formats) with directed and random frames, comparing miso, frame_active,
//   write events and register readback against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

  logic clk_serial = 1'b0;
  always #5 clk_serial = ~clk_serial;

  logic        reset;
  logic        ss_n8, mosi8, miso8, wr_strobe8, frame_active8;
  logic [3:0]  rd_addr8, wr_addr8;
  logic [7:0]  rd_data8, wr_data8;
  logic        ss_n16, mosi16, miso16, wr_strobe16, frame_active16;
  logic [3:0]  rd_addr16, wr_addr16;
  logic [15:0] rd_data16, wr_data16;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic        err_clear8, err_clear16;
  logic [7:0]  err_count8, err_count16;
`endif

  spi_slave_regfile dut8 (
    .clk_serial(clk_serial), .reset(reset), .ss_n(ss_n8), .mosi(mosi8), .miso(miso8),
    .reg_rd_addr(rd_addr8), .reg_rd_data(rd_data8), .wr_strobe(wr_strobe8),
    .wr_addr(wr_addr8), .wr_data(wr_data8),
`ifdef SPI_SLAVE_ERR_CNT_EN
    .err_clear(err_clear8), .err_count(err_count8),
`endif
    .frame_active(frame_active8)
  );

  spi_slave_regfile #(.ADDR_BYTES(2), .DATA_BYTES(2)) dut16 (
    .clk_serial(clk_serial), .reset(reset), .ss_n(ss_n16), .mosi(mosi16), .miso(miso16),
    .reg_rd_addr(rd_addr16), .reg_rd_data(rd_data16), .wr_strobe(wr_strobe16),
    .wr_addr(wr_addr16), .wr_data(wr_data16),
`ifdef SPI_SLAVE_ERR_CNT_EN
    .err_clear(err_clear16), .err_count(err_count16),
`endif
    .frame_active(frame_active16)
  );

  int checks;
  int errors;

  // Reference state: register contents and abort counts per instance.
  logic [15:0] mem8 [16];
  logic [15:0] mem16 [16];
  int          err_exp8, err_exp16;

  // Per-edge records of one frame (bit i = value just after edge i).
  logic [63:0] rec_miso, rec_fa, rec_stb, exp_miso, exp_fa, exp_stb;
  logic [3:0]  rec_waddr, exp_waddr;
  logic [15:0] rec_wdata, exp_wdata;

  // Drive nbits of word MSB first with ss_n low, then one edge with ss_n high.
  task automatic run_frame(input int which, input int nbits, input logic [63:0] word, input bit clr);
    logic s, b;
    rec_miso = '0; rec_fa = '0; rec_stb = '0; rec_waddr = '0; rec_wdata = '0;
    for (int i = 0; i <= nbits; i++) begin
      if (i < nbits) begin s = 1'b0; b = word[nbits-1-i]; end
      else           begin s = 1'b1; b = 1'b0; end
      if (which == 0) begin ss_n8 = s; mosi8 = b; end
      else            begin ss_n16 = s; mosi16 = b; end
`ifdef SPI_SLAVE_ERR_CNT_EN
      if (i == nbits && clr) begin
        if (which == 0) err_clear8 = 1'b1; else err_clear16 = 1'b1;
      end
`endif
      @(posedge clk_serial); #1;
`ifdef SPI_SLAVE_ERR_CNT_EN
      err_clear8 = 1'b0; err_clear16 = 1'b0;
`endif
      if (which == 0) begin
        rec_miso[i] = miso8; rec_fa[i] = frame_active8; rec_stb[i] = wr_strobe8;
        if (wr_strobe8) begin rec_waddr = wr_addr8; rec_wdata = {8'h00, wr_data8}; end
      end else begin
        rec_miso[i] = miso16; rec_fa[i] = frame_active16; rec_stb[i] = wr_strobe16;
        if (wr_strobe16) begin rec_waddr = wr_addr16; rec_wdata = wr_data16; end
      end
    end
  endtask

  // Frame-level reference: a frame completes after AW+DW bits; frame_active covers
  // edges before the completion edge; reads present MSB..LSB on edges AW-1..AW+DW-2.
  task automatic predict(input int which, input int nbits, input logic [63:0] word, input bit clr);
    int aw, dw;
    logic [63:0] addr, data;
    logic [3:0]  idx;
    logic [15:0] cur;
    bit rd, complete;
    aw = (which == 0) ? 8 : 16;
    dw = aw;
    exp_miso = '0; exp_fa = '0; exp_stb = '0; exp_waddr = '0; exp_wdata = '0;
    complete = (nbits >= aw + dw);
    rd       = word[nbits-1];
    addr     = (nbits >= aw) ? (word >> (nbits - aw)) : 64'd0;
    idx      = addr[3:0];
    cur      = (which == 0) ? mem8[idx] : mem16[idx];
    for (int i = 0; i < nbits; i++) exp_fa[i] = (i < aw + dw - 1);
    if (rd && nbits >= aw) begin
      for (int k = 0; k < dw; k++) if (aw - 1 + k < nbits) exp_miso[aw-1+k] = cur[dw-1-k];
    end else if (!rd && complete) begin
      data = (word >> (nbits - aw - dw)) & ((64'd1 << dw) - 64'd1);
      exp_stb[aw+dw-1] = 1'b1;
      exp_waddr = idx;
      exp_wdata = data[15:0];
      if (which == 0) mem8[idx] = data[15:0]; else mem16[idx] = data[15:0];
    end
    if (which == 0) begin
      if (clr) err_exp8 = 0; else if (!complete && err_exp8 < 255) err_exp8++;
    end else begin
      if (clr) err_exp16 = 0; else if (!complete && err_exp16 < 255) err_exp16++;
    end
  endtask

  task automatic test_reset();
    checks += 10;
    if (miso8 !== 1'b0)          begin errors++; $display("FAIL reset miso8 got %b want 0", miso8); end
    if (wr_strobe8 !== 1'b0)     begin errors++; $display("FAIL reset wr_strobe8 got %b want 0", wr_strobe8); end
    if (wr_addr8 !== 4'h0)       begin errors++; $display("FAIL reset wr_addr8 got %h want 0", wr_addr8); end
    if (wr_data8 !== 8'h00)      begin errors++; $display("FAIL reset wr_data8 got %h want 0", wr_data8); end
    if (frame_active8 !== 1'b0)  begin errors++; $display("FAIL reset frame_active8 got %b want 0", frame_active8); end
    if (miso16 !== 1'b0)         begin errors++; $display("FAIL reset miso16 got %b want 0", miso16); end
    if (wr_strobe16 !== 1'b0)    begin errors++; $display("FAIL reset wr_strobe16 got %b want 0", wr_strobe16); end
    if (wr_addr16 !== 4'h0)      begin errors++; $display("FAIL reset wr_addr16 got %h want 0", wr_addr16); end
    if (wr_data16 !== 16'h0000)  begin errors++; $display("FAIL reset wr_data16 got %h want 0", wr_data16); end
    if (frame_active16 !== 1'b0) begin errors++; $display("FAIL reset frame_active16 got %b want 0", frame_active16); end
    for (int r = 0; r < 16; r++) begin
      rd_addr8 = 4'(r); rd_addr16 = 4'(r); #1;
      checks += 2;
      if (rd_data8 !== 8'h00)   begin errors++; $display("FAIL reset reg8[%0d] got %h want 0", r, rd_data8); end
      if (rd_data16 !== 16'h0)  begin errors++; $display("FAIL reset reg16[%0d] got %h want 0", r, rd_data16); end
    end
`ifdef SPI_SLAVE_ERR_CNT_EN
    checks += 2;
    if (err_count8 !== 8'd0)  begin errors++; $display("FAIL reset err_count8 got %0d want 0", err_count8); end
    if (err_count16 !== 8'd0) begin errors++; $display("FAIL reset err_count16 got %0d want 0", err_count16); end
`endif
  endtask

  // 8-bit write 0x05/0xA7, read back 0x85, overlong 24-bit write.
  task automatic test_write_read();
    logic [63:0] words [3] = '{64'h05A7, 64'h8500, 64'h0955FF};
    int          lens  [3] = '{16, 16, 24};
    logic [7:0]  got;
    for (int f = 0; f < 3; f++) begin
      run_frame(0, lens[f], words[f], 1'b0);
      predict(0, lens[f], words[f], 1'b0);
      checks += 4;
      if (rec_miso !== exp_miso) begin errors++; $display("FAIL wr8[%0d] miso got %h want %h", f, rec_miso, exp_miso); end
      if (rec_fa !== exp_fa)     begin errors++; $display("FAIL wr8[%0d] frame_active got %h want %h", f, rec_fa, exp_fa); end
      if (rec_stb !== exp_stb)   begin errors++; $display("FAIL wr8[%0d] wr_strobe got %h want %h", f, rec_stb, exp_stb); end
      if ({rec_waddr, rec_wdata} !== {exp_waddr, exp_wdata})
        begin errors++; $display("FAIL wr8[%0d] wr_addr/data got %h/%h want %h/%h", f, rec_waddr, rec_wdata, exp_waddr, exp_wdata); end
      if (f == 1) begin
        for (int k = 0; k < 8; k++) got[7-k] = rec_miso[7+k];
        checks++;
        if (got !== 8'hA7) begin errors++; $display("FAIL rd8 serial got %h want a7", got); end
      end
    end
    rd_addr8 = 4'd5; #1;
    checks++;
    if (rd_data8 !== 8'hA7) begin errors++; $display("FAIL wr8 readback reg5 got %h want a7", rd_data8); end
    rd_addr8 = 4'd9; #1;
    checks++;
    if (rd_data8 !== 8'h55) begin errors++; $display("FAIL overlong readback reg9 got %h want 55", rd_data8); end
  endtask

  // 16-bit frames, including an index above NUM_REGS aliasing onto register 3.
  task automatic test_wide();
    logic [63:0] words [4] = '{64'h0003BEEF, 64'h80030000, 64'h80130000, 64'h00131234};
    logic [15:0] got;
    for (int f = 0; f < 4; f++) begin
      run_frame(1, 32, words[f], 1'b0);
      predict(1, 32, words[f], 1'b0);
      checks += 4;
      if (rec_miso !== exp_miso) begin errors++; $display("FAIL wide[%0d] miso got %h want %h", f, rec_miso, exp_miso); end
      if (rec_fa !== exp_fa)     begin errors++; $display("FAIL wide[%0d] frame_active got %h want %h", f, rec_fa, exp_fa); end
      if (rec_stb !== exp_stb)   begin errors++; $display("FAIL wide[%0d] wr_strobe got %h want %h", f, rec_stb, exp_stb); end
      if ({rec_waddr, rec_wdata} !== {exp_waddr, exp_wdata})
        begin errors++; $display("FAIL wide[%0d] wr_addr/data got %h/%h want %h/%h", f, rec_waddr, rec_wdata, exp_waddr, exp_wdata); end
      if (f == 1 || f == 2) begin
        for (int k = 0; k < 16; k++) got[15-k] = rec_miso[15+k];
        checks++;
        if (got !== 16'hBEEF) begin errors++; $display("FAIL wide[%0d] serial got %h want beef", f, got); end
      end
    end
    rd_addr16 = 4'd3; #1;
    checks++;
    if (rd_data16 !== 16'h1234) begin errors++; $display("FAIL wide alias reg3 got %h want 1234", rd_data16); end
  endtask

  // Write reg2, abort a write to reg2 after 12 bits, then read reg2 in a full frame.
  task automatic test_abort();
    logic [63:0] words [3] = '{64'h025A, 64'h02C, 64'h8200};
    int          lens  [3] = '{16, 12, 16};
    for (int f = 0; f < 3; f++) begin
      run_frame(0, lens[f], words[f], 1'b0);
      predict(0, lens[f], words[f], 1'b0);
      checks += 4;
      if (rec_miso !== exp_miso) begin errors++; $display("FAIL abort[%0d] miso got %h want %h", f, rec_miso, exp_miso); end
      if (rec_fa !== exp_fa)     begin errors++; $display("FAIL abort[%0d] frame_active got %h want %h", f, rec_fa, exp_fa); end
      if (rec_stb !== exp_stb)   begin errors++; $display("FAIL abort[%0d] wr_strobe got %h want %h", f, rec_stb, exp_stb); end
      if ({rec_waddr, rec_wdata} !== {exp_waddr, exp_wdata})
        begin errors++; $display("FAIL abort[%0d] wr_addr/data got %h/%h want %h/%h", f, rec_waddr, rec_wdata, exp_waddr, exp_wdata); end
`ifdef SPI_SLAVE_ERR_CNT_EN
      checks++;
      if (err_count8 !== 8'(err_exp8)) begin errors++; $display("FAIL abort[%0d] err_count got %0d want %0d", f, err_count8, err_exp8); end
`endif
    end
    rd_addr8 = 4'd2; #1;
    checks++;
    if (rd_data8 !== 8'h5A) begin errors++; $display("FAIL abort reg2 got %h want 5a", rd_data8); end
  endtask

  // Reset pulse after 4 address bits while ss_n stays low; nothing may decode until ss_n rises.
  task automatic test_reset_mid_frame();
    logic [15:0] w;
    bit saw_stb, saw_fa, saw_miso;
    w = 16'h0677; saw_stb = 0; saw_fa = 0; saw_miso = 0;
    ss_n8 = 1'b0;
    for (int i = 0; i < 28; i++) begin
      mosi8 = (i < 16) ? w[15-i] : w[31-i];
      reset = (i == 4);
      @(posedge clk_serial); #1;
      if (i >= 4) begin
        if (wr_strobe8) saw_stb = 1;
        if (frame_active8) saw_fa = 1;
        if (miso8) saw_miso = 1;
      end
    end
    reset = 1'b0;
    ss_n8 = 1'b1; mosi8 = 1'b0;
    @(posedge clk_serial); #1;
    for (int r = 0; r < 16; r++) begin mem8[r] = '0; mem16[r] = '0; end
    err_exp8 = 0; err_exp16 = 0;
    rd_addr8 = 4'd6; #1;
    checks += 4;
    if (saw_stb)  begin errors++; $display("FAIL rst_mid wr_strobe got 1 want 0"); end
    if (saw_fa)   begin errors++; $display("FAIL rst_mid frame_active got 1 want 0"); end
    if (saw_miso) begin errors++; $display("FAIL rst_mid miso got 1 want 0"); end
    if (rd_data8 !== 8'h00) begin errors++; $display("FAIL rst_mid reg6 got %h want 00", rd_data8); end
    run_frame(0, 16, 64'h0677, 1'b0);
    predict(0, 16, 64'h0677, 1'b0);
    rd_addr8 = 4'd6; #1;
    checks += 3;
    if (rec_stb !== exp_stb) begin errors++; $display("FAIL rst_mid next wr_strobe got %h want %h", rec_stb, exp_stb); end
    if ({rec_waddr, rec_wdata} !== {exp_waddr, exp_wdata})
      begin errors++; $display("FAIL rst_mid next wr_addr/data got %h/%h want %h/%h", rec_waddr, rec_wdata, exp_waddr, exp_wdata); end
    if (rd_data8 !== 8'h77) begin errors++; $display("FAIL rst_mid next reg6 got %h want 77", rd_data8); end
  endtask

`ifdef SPI_SLAVE_ERR_CNT_EN
  task automatic test_err_count();
    // abort with clear on the same edge: clear wins
    run_frame(0, 5, 64'h15, 1'b1);
    predict(0, 5, 64'h15, 1'b1);
    checks++;
    if (err_count8 !== 8'd0) begin errors++; $display("FAIL err clear_vs_abort got %0d want 0", err_count8); end
    for (int n = 0; n < 260; n++) begin
      run_frame(0, 1, 64'(n & 1), 1'b0);
      predict(0, 1, 64'(n & 1), 1'b0);
    end
    checks++;
    if (err_count8 !== 8'd255) begin errors++; $display("FAIL err saturate got %0d want 255", err_count8); end
    err_clear8 = 1'b1;
    @(posedge clk_serial); #1;
    err_clear8 = 1'b0;
    err_exp8 = 0;
    checks++;
    if (err_count8 !== 8'd0) begin errors++; $display("FAIL err clear got %0d want 0", err_count8); end
  endtask
`endif

  task automatic test_random();
    int which, full, mode, nbits;
    bit clr;
    logic [63:0] word;
    for (int n = 0; n < 80; n++) begin
      which = $urandom_range(0, 1);
      full  = (which == 0) ? 16 : 32;
      mode  = $urandom_range(0, 3);
      if (mode == 2)      nbits = $urandom_range(1, full - 1);
      else if (mode == 3) nbits = $urandom_range(full + 1, full + 8);
      else                nbits = full;
      word = {$urandom(), $urandom()};
      word = word & ((64'd1 << nbits) - 64'd1);
      clr  = ($urandom_range(0, 7) == 0);
      run_frame(which, nbits, word, clr);
      predict(which, nbits, word, clr);
      checks += 4;
      if (rec_miso !== exp_miso) begin errors++; $display("FAIL rand[%0d] miso got %h want %h", n, rec_miso, exp_miso); end
      if (rec_fa !== exp_fa)     begin errors++; $display("FAIL rand[%0d] frame_active got %h want %h", n, rec_fa, exp_fa); end
      if (rec_stb !== exp_stb)   begin errors++; $display("FAIL rand[%0d] wr_strobe got %h want %h", n, rec_stb, exp_stb); end
      if ({rec_waddr, rec_wdata} !== {exp_waddr, exp_wdata})
        begin errors++; $display("FAIL rand[%0d] wr_addr/data got %h/%h want %h/%h", n, rec_waddr, rec_wdata, exp_waddr, exp_wdata); end
`ifdef SPI_SLAVE_ERR_CNT_EN
      checks += 2;
      if (err_count8 !== 8'(err_exp8))   begin errors++; $display("FAIL rand[%0d] err_count8 got %0d want %0d", n, err_count8, err_exp8); end
      if (err_count16 !== 8'(err_exp16)) begin errors++; $display("FAIL rand[%0d] err_count16 got %0d want %0d", n, err_count16, err_exp16); end
`endif
    end
  endtask

  task automatic test_regfile();
    for (int r = 0; r < 16; r++) begin
      rd_addr8 = 4'(r); rd_addr16 = 4'(r); #1;
      checks += 2;
      if (rd_data8 !== mem8[r][7:0]) begin errors++; $display("FAIL regfile8[%0d] got %h want %h", r, rd_data8, mem8[r][7:0]); end
      if (rd_data16 !== mem16[r])    begin errors++; $display("FAIL regfile16[%0d] got %h want %h", r, rd_data16, mem16[r]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    ss_n8 = 1'b1; mosi8 = 1'b0; rd_addr8 = '0;
    ss_n16 = 1'b1; mosi16 = 1'b0; rd_addr16 = '0;
`ifdef SPI_SLAVE_ERR_CNT_EN
    err_clear8 = 1'b0; err_clear16 = 1'b0;
`endif
    for (int r = 0; r < 16; r++) begin mem8[r] = '0; mem16[r] = '0; end
    err_exp8 = 0; err_exp16 = 0;
    repeat (2) @(posedge clk_serial);
    #1 reset = 1'b0;
    @(posedge clk_serial); #1;

    test_reset();
    test_write_read();
    test_wide();
    test_abort();
    test_reset_mid_frame();
`ifdef SPI_SLAVE_ERR_CNT_EN
    test_err_count();
`endif
    test_random();
    test_regfile();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI responder (target) for the frame format driven by the team's SPI master: address field, then write data or read data, MSB first, one bit per clk_serial cycle while ss_n is low.
- Holds a small register file that the SPI side can write and read. Exposes a local read port, plus a write-event strobe for downstream logic.
- Sits on the board/test side of the serial link, or in a loopback bench opposite the master. Entirely in the clk_serial domain.

Parameters:
- ADDR_BYTES, 1, address field length in bytes (1 or 2). Field MSB is the read flag (1 = read); the remaining bits are the register index.
- DATA_BYTES, 1, data field length in bytes (1 or 2). Register width is DW = 8*DATA_BYTES.
- NUM_REGS, 16, number of registers (power of two, 2..256). Index width IW = log2(NUM_REGS).
- RESET_VAL, 0, reset value of every register.

Ports:
- clk_serial  in  1  serial clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- ss_n  in  1  slave select, active low.
- mosi  in  1  serial data from master, sampled on posedge clk_serial while ss_n=0.
- miso  out  1  serial data to master.
- reg_rd_addr  in  IW  local read index.
- reg_rd_data  out  DW  combinational readback of register[reg_rd_addr].
- wr_strobe  out  1  one-cycle pulse when an SPI write commits.
- wr_addr  out  IW  index of the committed write; valid with wr_strobe.
- wr_data  out  DW  data of the committed write; valid with wr_strobe.
- frame_active  out  1  high from the first sampled bit until the frame completes or aborts.

Behaviour:
- Reset (reset=1 at posedge):
  - All registers load RESET_VAL.
  - miso=0, wr_strobe=0, wr_addr=0, wr_data=0, frame_active=0.
  - Bit counter and shift registers cleared.
  - State goes to WAIT_HIGH, so a frame that was interrupted mid-way is never decoded.
- State IDLE:
  - At a posedge with ss_n=0, sample mosi as the address MSB, i.e. the read flag.
  - Set frame_active=1, counter = 8*ADDR_BYTES-2, then go to ADDR.
- State ADDR:
  - Each posedge with ss_n=0: shift mosi in and decrement the counter.
  - On the edge that samples the last address bit:
    - If the read flag is 0: counter = DW-1, go to WDATA.
    - If the read flag is 1: load the read shifter with register[index], where the index includes the bit just sampled. miso takes data bit DW-1 from this same edge, so the master sees the MSB on its first read sample. Counter = DW-1, go to RDATA.
- State WDATA:
  - Each posedge with ss_n=0: shift mosi in.
  - On the last data bit:
    - Write register[index] at that same edge.
    - wr_strobe=1 for exactly one cycle, with wr_addr/wr_data valid.
    - Go to WAIT_HIGH.
- State RDATA:
  - Each posedge with ss_n=0: shift the read shifter left and drive miso with the next bit.
  - After DW-1 shifts the master has sampled all DW bits. On the edge after that last shift, miso=0 and go to WAIT_HIGH.
- State WAIT_HIGH:
  - Ignore all mosi bits; miso=0, frame_active=0.
  - When ss_n=1, go to IDLE.
- Index handling: index bits above IW are ignored (index modulo NUM_REGS). This applies to both reads and writes.
- Early ss_n rise (in ADDR/WDATA/RDATA): abort. No write, no wr_strobe, frame_active=0, miso=0, go to IDLE.
- Pauses: ss_n is sampled every edge. Bits are counted only on edges with ss_n=0, so there are no gaps inside a frame.
- miso whenever ss_n=1: 0.
- Register readback: reg_rd_data shows the new value the cycle after the commit edge. A local read and an SPI write to the same index in the same cycle returns the old value.
- Reset asserted mid-frame: the frame is discarded and no write occurs. The block then waits for ss_n high before it decodes again.

Optional Feature:
- Macro: SPI_SLAVE_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0], reset to 0.
  - Increments by 1 on every aborted frame (ss_n rise in ADDR/WDATA/RDATA) and saturates at 255.
  - Adds input err_clear, which zeroes the counter at the next posedge. If an abort and err_clear happen in the same cycle, clear wins.
- Not defined: no err_count or err_clear ports and no counter logic. Abort behaviour is otherwise identical.

Test Plan:
- Write, ADDR_BYTES=1, DATA_BYTES=1: frame 0x05 then 0xA7 (16 bits) → wr_strobe one cycle, wr_addr=5, wr_data=0xA7; reg_rd_addr=5 then gives 0xA7.
- Read back: frame address 0x85 then 8 idle bits → miso carries 1,0,1,0,0,1,1,1 on the 8 posedges after the address; frame_active low afterwards; no wr_strobe.
- 16-bit mode, ADDR_BYTES=2, DATA_BYTES=2: write 0x0003 / 0xBEEF, then read 0x8003 → miso serialises 0xBEEF MSB first; index 0x13 with NUM_REGS=16 aliases to 3.
- Abort: ss_n rises after 12 of 16 bits of a write to index 2 → register 2 keeps its value, no wr_strobe, next full frame decodes normally (err_count=1 if SPI_SLAVE_ERR_CNT_EN).
- Reset mid-frame with ss_n held low: reset pulses after 4 address bits and the master continues the frame → no write; decoding resumes only after ss_n goes high, and the following frame decodes correctly.
- Overlong frame: ss_n held low for 24 bits on a 16-bit write → write commits once at bit 16, extra bits are ignored, and miso stays 0.
